// File: rtl/buffer_pkg.sv
// Shared types and constants for the UART-to-game holding buffer.
package buffer_pkg;

  localparam int unsigned DATA_WIDTH = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/buffer_rise_detect.sv
// Rising-edge detector for the receiver's level-valid ready signal.
module rise_detect (
  input  logic clk,
  input  logic nRst,
  input  logic i_ready,
  output logic o_rise_c
);

  logic r_ready_q;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) r_ready_q <= 1'b0;
    else       r_ready_q <= i_ready;
  end

  // Clearing to 0 on reset makes an already-high ready count as one rise.
  assign o_rise_c = i_ready & ~r_ready_q;

endmodule

// File: rtl/buffer.sv
// One-deep holding register between the UART receiver and the game logic.
module buffer
  import buffer_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             ready,
  input  logic [WIDTH-1:0] Rx_byte,
  input  logic             game_rdy,
  output logic [WIDTH-1:0] guess
);

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_guess;
  logic             w_rise;

  rise_detect u_rise_detect (
    .clk      (clk),
    .nRst     (nRst),
    .i_ready  (ready),
    .o_rise_c (w_rise)
  );

  // A new byte always overwrites the held one; a transfer hands out the old one.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= EMPTY;
      r_data  <= '0;
      r_guess <= '0;
    end else if (r_state == EMPTY) begin
      if (w_rise) begin
        r_data  <= Rx_byte;
        r_state <= FULL;
      end
    end else begin
      if (game_rdy) r_guess <= r_data;
      if (w_rise)        r_data  <= Rx_byte;
      else if (game_rdy) r_state <= EMPTY;
    end
  end

  assign guess = r_guess;

endmodule

// File: tb/tb_buffer.sv
// Directed bench for buffer: vector table plus reset corner sequences.
module tb_buffer;
  import buffer_pkg::*;

  localparam int unsigned W = 8;

  logic         clk;
  logic         nRst;
  logic         ready;
  logic [W-1:0] Rx_byte;
  logic         game_rdy;
  logic [W-1:0] guess;

  int errors = 0;
  int checks = 0;

  buffer #(.WIDTH(W)) dut (
    .clk      (clk),
    .nRst     (nRst),
    .ready    (ready),
    .Rx_byte  (Rx_byte),
    .game_rdy (game_rdy),
    .guess    (guess)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         ready;
    logic [W-1:0] rx;
    logic         game_rdy;
    logic [W-1:0] exp_guess;
    logic         exp_full;
  } vec_t;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input logic exp_full);
    logic [W-1:0] act;
    act = W'(dut.r_state == FULL);
    check(name, act, W'(exp_full));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[20];

  initial begin
    // Vectors: inputs applied before an edge, expectations sampled just after it.
    vecs[0]  = '{1'b1, 8'h05, 1'b0, 8'h00, 1'b1};
    vecs[1]  = '{1'b1, 8'h05, 1'b0, 8'h00, 1'b1};
    vecs[2]  = '{1'b0, 8'h05, 1'b1, 8'h05, 1'b0};
    vecs[3]  = '{1'b0, 8'h05, 1'b1, 8'h05, 1'b0};
    vecs[4]  = '{1'b1, 8'hA6, 1'b1, 8'h05, 1'b1};
    vecs[5]  = '{1'b1, 8'hA6, 1'b1, 8'hA6, 1'b0};
    vecs[6]  = '{1'b1, 8'h33, 1'b1, 8'hA6, 1'b0};
    vecs[7]  = '{1'b1, 8'h33, 1'b1, 8'hA6, 1'b0};
    vecs[8]  = '{1'b1, 8'h33, 1'b1, 8'hA6, 1'b0};
    vecs[9]  = '{1'b0, 8'h05, 1'b0, 8'hA6, 1'b0};
    vecs[10] = '{1'b1, 8'h05, 1'b0, 8'hA6, 1'b1};
    vecs[11] = '{1'b0, 8'h09, 1'b0, 8'hA6, 1'b1};
    vecs[12] = '{1'b1, 8'h09, 1'b0, 8'hA6, 1'b1};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 8'h09, 1'b0};
    vecs[14] = '{1'b1, 8'h05, 1'b0, 8'h09, 1'b1};
    vecs[15] = '{1'b0, 8'h05, 1'b0, 8'h09, 1'b1};
    vecs[16] = '{1'b1, 8'h07, 1'b1, 8'h05, 1'b1};
    vecs[17] = '{1'b0, 8'h07, 1'b1, 8'h07, 1'b0};
    vecs[18] = '{1'b0, 8'h44, 1'b1, 8'h07, 1'b0};
    vecs[19] = '{1'b1, 8'hC3, 1'b0, 8'h07, 1'b1};

    nRst     = 1'b0;
    ready    = 1'b0;
    Rx_byte  = 8'h05;
    game_rdy = 1'b0;
    tick();
    tick();
    check("reset_guess_during", guess, 8'h00);
    check_state("reset_state_during", 1'b0);
    nRst = 1'b1;
    tick();
    check("reset_guess_after", guess, 8'h00);
    check_state("reset_state_after", 1'b0);

    foreach (vecs[i]) begin
      ready    = vecs[i].ready;
      Rx_byte  = vecs[i].rx;
      game_rdy = vecs[i].game_rdy;
      tick();
      check($sformatf("vec%0d_guess", i), guess, vecs[i].exp_guess);
      check_state($sformatf("vec%0d_state", i), vecs[i].exp_full);
    end

    // Asynchronous reset while FULL: guess clears with no clock edge, held byte is lost.
    ready    = 1'b0;
    game_rdy = 1'b0;
    #2;
    nRst = 1'b0;
    #1;
    check("async_reset_guess", guess, 8'h00);
    check_state("async_reset_state", 1'b0);
    tick();
    nRst     = 1'b1;
    game_rdy = 1'b1;
    tick();
    check("lost_byte_guess", guess, 8'h00);
    check_state("lost_byte_state", 1'b0);
    tick();
    check("lost_byte_guess2", guess, 8'h00);

    // ready already high when reset releases yields exactly one capture.
    nRst     = 1'b0;
    ready    = 1'b1;
    Rx_byte  = 8'h5A;
    game_rdy = 1'b1;
    tick();
    nRst = 1'b1;
    tick();
    check("ready_at_release_guess", guess, 8'h00);
    check_state("ready_at_release_state", 1'b1);
    Rx_byte = 8'h11;
    tick();
    check("ready_at_release_xfer", guess, 8'h5A);
    check_state("ready_at_release_empty", 1'b0);
    tick();
    check("ready_held_no_recapture", guess, 8'h5A);
    check_state("ready_held_still_empty", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
